// File: rtl/pc_context_bank.sv
// Multi-process program-counter bank with a round-robin scheduler.
// It holds one PC per hardware process and switches contexts on yield, exit or quantum expiry.
module pc_context_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NPROCESS   = 4,
    parameter int PID_WIDTH  = 2,
    parameter int QUANTUM    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  pc_src,
    input  logic                  zero,
    input  logic                  jmp,
    input  logic                  jr,
    input  logic                  jal,
    input  logic [DATA_WIDTH-1:0] target,
    input  logic                  yield,
    input  logic                  exit_proc,
    input  logic                  wr_en,
    input  logic [PID_WIDTH-1:0]  wr_pid,
    input  logic [DATA_WIDTH-1:0] wr_pc,
    input  logic                  wr_activate,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [PID_WIDTH-1:0]  cur_pid,
    output logic                  switching,
    output logic                  idle,
    output logic [NPROCESS-1:0]   active_mask
);

    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam int SW = PID_WIDTH + 1;

    typedef enum logic [1:0] {ST_RUN, ST_SWITCH, ST_IDLE} state_t;

    state_t                state_reg;
    logic [PID_WIDTH-1:0]  cur_pid_reg;
    logic [QW-1:0]         qcount_reg;
    logic [NPROCESS-1:0]   active_reg;
    logic [NPROCESS-1:0]   active_next;
    logic [DATA_WIDTH-1:0] pc_reg  [NPROCESS];
    logic [DATA_WIDTH-1:0] pc_next [NPROCESS];

    logic                  run_step;
    logic                  taken;
    logic                  quantum_end;
    logic                  switch_trigger;
    logic [DATA_WIDTH-1:0] seq_pc;

    logic [PID_WIDTH-1:0]  cand_pid   [NPROCESS];
    logic                  cand_valid [NPROCESS];
    logic                  found_chain[NPROCESS+1];
    logic [PID_WIDTH-1:0]  pid_chain  [NPROCESS+1];

    assign pc_out      = pc_reg[cur_pid_reg];
    assign cur_pid     = cur_pid_reg;
    assign switching   = (state_reg == ST_SWITCH);
    assign idle        = (state_reg == ST_IDLE);
    assign active_mask = active_reg;

    assign run_step       = (state_reg == ST_RUN) && !halt;
    assign taken          = (pc_src & zero) | jmp | jr | jal;
    assign seq_pc         = pc_out + DATA_WIDTH'(1);
    assign quantum_end    = (qcount_reg == QW'(QUANTUM - 1));
    assign switch_trigger = yield | exit_proc | quantum_end;

    assign found_chain[NPROCESS] = 1'b0;
    assign pid_chain[NPROCESS]   = cur_pid_reg;

    generate
        for (genvar gi = 0; gi < NPROCESS; gi++) begin : g_proc
            logic          wr_hit;
            logic          cur_hit;
            logic [SW-1:0] sum;
            logic [SW-1:0] wrapped;

            // The write port takes priority over the running process's own update.
            assign wr_hit  = wr_en && (wr_pid == PID_WIDTH'(gi));
            assign cur_hit = run_step && (cur_pid_reg == PID_WIDTH'(gi));

            assign pc_next[gi] = wr_hit  ? wr_pc :
                                 cur_hit ? (taken ? target : seq_pc) :
                                           pc_reg[gi];

            assign active_next[gi] = (wr_hit && wr_activate) ? 1'b1 :
                                     (cur_hit && exit_proc)  ? 1'b0 :
                                                               active_reg[gi];

            // Candidate gi is the process at distance gi+1 after cur, so the current one is scanned last.
            assign sum            = {1'b0, cur_pid_reg} + SW'(gi + 1);
            assign wrapped        = (sum >= SW'(NPROCESS)) ? (sum - SW'(NPROCESS)) : sum;
            assign cand_pid[gi]   = wrapped[PID_WIDTH-1:0];
            assign cand_valid[gi] = active_reg[cand_pid[gi]];

            assign found_chain[gi] = cand_valid[gi] | found_chain[gi+1];
            assign pid_chain[gi]   = cand_valid[gi] ? cand_pid[gi] : pid_chain[gi+1];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg     <= '{default: '0};
            active_reg <= NPROCESS'(1);
        end else begin
            pc_reg     <= pc_next;
            active_reg <= active_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_RUN;
            cur_pid_reg <= '0;
            qcount_reg  <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!halt) begin
                        if (switch_trigger) begin
                            state_reg  <= ST_SWITCH;
                            qcount_reg <= '0;
                        end else begin
                            qcount_reg <= qcount_reg + QW'(1);
                        end
                    end
                end
                ST_SWITCH: begin
                    cur_pid_reg <= pid_chain[0];
                    state_reg   <= found_chain[0] ? ST_RUN : ST_IDLE;
                end
                ST_IDLE: begin
                    if (|active_reg) state_reg <= ST_SWITCH;
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_context_bank.sv
// Randomized and directed bench for pc_context_bank.
// The reference model keeps PCs, the active set and the scheduler state as plain variables.
module tb_pc_context_bank;

    localparam int DW = 32;
    localparam int NP = 3;
    localparam int PW = 2;
    localparam int Q  = 4;

    logic          clock;
    logic          reset;
    logic          halt, pc_src, zero, jmp, jr, jal;
    logic [DW-1:0] target;
    logic          yield, exit_proc, wr_en, wr_activate;
    logic [PW-1:0] wr_pid;
    logic [DW-1:0] wr_pc;
    logic [DW-1:0] pc_out;
    logic [PW-1:0] cur_pid;
    logic          switching, idle;
    logic [NP-1:0] active_mask;

    pc_context_bank #(
        .DATA_WIDTH(DW), .NPROCESS(NP), .PID_WIDTH(PW), .QUANTUM(Q)
    ) dut (
        .clock(clock), .reset(reset), .halt(halt), .pc_src(pc_src), .zero(zero),
        .jmp(jmp), .jr(jr), .jal(jal), .target(target), .yield(yield),
        .exit_proc(exit_proc), .wr_en(wr_en), .wr_pid(wr_pid), .wr_pc(wr_pc),
        .wr_activate(wr_activate), .pc_out(pc_out), .cur_pid(cur_pid),
        .switching(switching), .idle(idle), .active_mask(active_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: 0 = running, 1 = switching bubble, 2 = idle.
    logic [DW-1:0] m_pc [NP];
    logic [NP-1:0] m_act;
    int            m_cur, m_q, m_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_pc[i] = '0;
        m_act   = NP'(1);
        m_cur   = 0;
        m_q     = 0;
        m_state = 0;
    endtask

    task automatic model_step();
        logic [DW-1:0] n_pc [NP];
        logic [NP-1:0] n_act;
        int            n_cur, n_q, n_state, p;
        n_pc    = m_pc;
        n_act   = m_act;
        n_cur   = m_cur;
        n_q     = m_q;
        n_state = m_state;
        case (m_state)
            0: if (!halt) begin
                if ((pc_src && zero) || jmp || jr || jal) n_pc[m_cur] = target;
                else                                      n_pc[m_cur] = m_pc[m_cur] + 32'd1;
                n_q = m_q + 1;
                if (yield || exit_proc || m_q == Q - 1) begin
                    n_state = 1;
                    n_q     = 0;
                    if (exit_proc) n_act[m_cur] = 1'b0;
                end
            end
            1: begin
                n_state = 2;
                for (int k = 1; k <= NP; k++) begin
                    p = (m_cur + k) % NP;
                    if (m_act[p]) begin
                        n_cur   = p;
                        n_state = 0;
                        break;
                    end
                end
            end
            default: if (m_act != '0) n_state = 1;
        endcase
        if (wr_en && int'(wr_pid) < NP) begin
            n_pc[wr_pid] = wr_pc;
            if (wr_activate) n_act[wr_pid] = 1'b1;
        end
        m_pc    = n_pc;
        m_act   = n_act;
        m_cur   = n_cur;
        m_q     = n_q;
        m_state = n_state;
    endtask

    task automatic compare_model();
        check("pc_out",      64'(pc_out),      64'(m_pc[m_cur]));
        check("cur_pid",     64'(cur_pid),     64'(m_cur));
        check("switching",   64'(switching),   64'(m_state == 1));
        check("idle",        64'(idle),        64'(m_state == 2));
        check("active_mask", 64'(active_mask), 64'(m_act));
    endtask

    task automatic clear_inputs();
        halt = 0; pc_src = 0; zero = 0; jmp = 0; jr = 0; jal = 0; target = '0;
        yield = 0; exit_proc = 0; wr_en = 0; wr_activate = 0; wr_pid = '0; wr_pc = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        compare_model();
        $display("cyc=%0d pid=%0d pc=%0h sw=%0b idle=%0b act=%b",
                 cyc, cur_pid, pc_out, switching, idle, active_mask);
    endtask

    // Called one time unit after a rising edge; reset acts without any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_pc_out",    64'(pc_out),      64'd0);
        check("rst_cur_pid",   64'(cur_pid),     64'd0);
        check("rst_switching", 64'(switching),   64'd0);
        check("rst_idle",      64'(idle),        64'd0);
        check("rst_active",    64'(active_mask), 64'd1);
        #2;
        reset = 1'b1;
        $display("reset applied at t=%0t", $time);
    endtask

    task automatic rand_inputs();
        halt        = ($urandom_range(0, 9) == 0);
        pc_src      = ($urandom_range(0, 9) < 3);
        zero        = $urandom_range(0, 1);
        jmp         = ($urandom_range(0, 19) == 0);
        jr          = ($urandom_range(0, 19) == 0);
        jal         = ($urandom_range(0, 19) == 0);
        target      = $urandom;
        yield       = ($urandom_range(0, 19) == 0);
        exit_proc   = ($urandom_range(0, 29) == 0);
        wr_en       = ($urandom_range(0, 9) == 0);
        wr_pid      = PW'($urandom_range(0, 3));
        wr_pc       = $urandom;
        wr_activate = $urandom_range(0, 1);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Sequential fetch from reset
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t1_seq_pc", 64'(pc_out), 64'(i));
            check("t1_pid",    64'(cur_pid), 64'd0);
        end

        // Branch not taken, taken, jal, halt
        do_reset();
        wr_en = 1; wr_pid = 0; wr_pc = 32'd10;
        tick();
        clear_inputs();
        pc_src = 1; zero = 0;
        tick(); check("t2_not_taken", 64'(pc_out), 64'd11);
        zero = 1; target = 32'd40;
        tick(); check("t2_taken", 64'(pc_out), 64'd40);
        clear_inputs(); jal = 1; target = 32'd7;
        tick(); check("t2_jal", 64'(pc_out), 64'd7);
        clear_inputs(); halt = 1;
        tick(); check("t2_halt_a", 64'(pc_out), 64'd7);
        tick(); check("t2_halt_b", 64'(pc_out), 64'd7);
        clear_inputs();

        // Quantum preemption and resume of the saved PC
        do_reset();
        wr_en = 1; wr_pid = 1; wr_pc = 32'd100; wr_activate = 1;
        tick();
        clear_inputs();
        repeat (3) tick();
        check("t3_bubble", 64'(switching), 64'd1);
        tick();
        check("t3_pid1", 64'(cur_pid), 64'd1);
        check("t3_pc100", 64'(pc_out), 64'd100);
        repeat (4) tick();
        check("t3_bubble2", 64'(switching), 64'd1);
        tick();
        check("t3_resume_pid", 64'(cur_pid), 64'd0);
        check("t3_resume_pc",  64'(pc_out),  64'd4);

        // Exit both processes, idle, then revive pid 2
        exit_proc = 1; tick(); exit_proc = 0;
        tick(); check("t4_pid1_pc", 64'(pc_out), 64'd104);
        exit_proc = 1; tick(); exit_proc = 0;
        tick(); check("t4_idle", 64'(idle), 64'd1);
        tick();
        wr_en = 1; wr_pid = 2; wr_pc = 32'd200; wr_activate = 1;
        tick();
        clear_inputs();
        tick(); check("t4_switch", 64'(switching), 64'd1);
        tick();
        check("t4_pid2", 64'(cur_pid), 64'd2);
        check("t4_pc200", 64'(pc_out), 64'd200);

        // Write port beats jump; out-of-range pid ignored
        do_reset();
        jmp = 1; target = 32'd50; wr_en = 1; wr_pid = 0; wr_pc = 32'd80;
        tick(); check("t5_wr_wins", 64'(pc_out), 64'd80);
        clear_inputs();
        halt = 1; wr_en = 1; wr_pid = 2'd3; wr_pc = 32'd999; wr_activate = 1;
        tick();
        check("t5_bad_pid_pc",  64'(pc_out),      64'd80);
        check("t5_bad_pid_act", 64'(active_mask), 64'd1);
        clear_inputs();

        // Asynchronous reset during SWITCH and during IDLE
        do_reset();
        yield = 1; tick(); yield = 0;
        check("t6_in_switch", 64'(switching), 64'd1);
        do_reset();
        exit_proc = 1; tick(); exit_proc = 0;
        tick(); check("t6_in_idle", 64'(idle), 64'd1);
        do_reset();

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                clear_inputs();
                do_reset();
            end
            rand_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
